// File: rtl/wta_disparity_select.sv
// Winner-take-all disparity selector: scans NUM_DISP costs per pixel and reports
// the minimum-cost disparity, its cost and a best/second-best uniqueness flag.
module wta_disparity_select #(
    parameter int NUM_DISP = 64,
    parameter int DISP_W   = 6,
    parameter int COST_W   = 8,
    parameter int UNIQ     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cost_valid,
    input  logic              cost_first,
    input  logic [COST_W-1:0] cost,
    output logic              out_valid,
    output logic [DISP_W-1:0] out_disp,
    output logic [COST_W-1:0] out_cost,
    output logic              out_unique,
    output logic              err_seq
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    localparam logic [DISP_W-1:0] LAST_D   = DISP_W'(NUM_DISP - 1);
    localparam logic [COST_W+5:0] UNIQ_MUL = (COST_W + 6)'(16 + UNIQ);

    logic [0:0]        state;
    logic [DISP_W-1:0] d_cnt;
    logic [COST_W-1:0] best;
    logic [COST_W-1:0] second;
    logic [DISP_W-1:0] best_d;

    logic              new_lt;
    logic [COST_W-1:0] nxt_best;
    logic [COST_W-1:0] nxt_second;
    logic [DISP_W-1:0] nxt_best_d;
    logic              last_beat;

    // Products are widened by 6 bits so second*16 and best*(16+UNIQ) never overflow.
    function automatic logic is_unique(input logic [COST_W-1:0] b,
                                       input logic [COST_W-1:0] s);
        logic [COST_W+5:0] lhs;
        logic [COST_W+5:0] rhs;
        lhs = {2'b00, s, 4'b0000};
        rhs = (COST_W + 6)'(b) * UNIQ_MUL;
        return lhs > rhs;
    endfunction

    // Running best/second update for the beat at index d_cnt; strict compare keeps
    // the lowest disparity on ties and pushes the tied value into second.
    always_comb begin
        new_lt     = cost < best;
        nxt_best   = new_lt ? cost : best;
        nxt_best_d = new_lt ? d_cnt : best_d;
        nxt_second = new_lt ? best : ((cost < second) ? cost : second);
        last_beat  = cost_valid && !cost_first && (state == S_ACCUM) && (d_cnt == LAST_D);
    end

    // Accumulation state and framing control
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            d_cnt  <= '0;
            best   <= '0;
            second <= '0;
            best_d <= '0;
        end else if (cost_valid) begin
            if (cost_first) begin
                best   <= cost;
                best_d <= '0;
                second <= '1;
                d_cnt  <= DISP_W'(1);
                state  <= S_ACCUM;
            end else if (state == S_ACCUM) begin
                best   <= nxt_best;
                best_d <= nxt_best_d;
                second <= nxt_second;
                if (last_beat) begin
                    d_cnt <= '0;
                    state <= S_IDLE;
                end else begin
                    d_cnt <= d_cnt + DISP_W'(1);
                end
            end
        end
    end

    // Result and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_disp   <= '0;
            out_cost   <= '0;
            out_unique <= 1'b0;
            err_seq    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            err_seq   <= 1'b0;
            if (cost_valid) begin
                if (cost_first) begin
                    err_seq <= (state == S_ACCUM);
                end else if (state == S_IDLE) begin
                    err_seq <= 1'b1;
                end else if (last_beat) begin
                    out_valid  <= 1'b1;
                    out_disp   <= nxt_best_d;
                    out_cost   <= nxt_best;
                    out_unique <= is_unique(nxt_best, nxt_second);
                end
            end
        end
    end

endmodule

// File: tb/tb_wta_disparity_select.sv
// Randomized bench for wta_disparity_select against a per-pixel array reference model.
module tb_wta_disparity_select;

    localparam int NUM_DISP = 64;
    localparam int DISP_W   = 6;
    localparam int COST_W   = 8;
    localparam int UNIQ     = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cost_valid = 1'b0;
    logic              cost_first = 1'b0;
    logic [COST_W-1:0] cost = '0;
    logic              out_valid;
    logic [DISP_W-1:0] out_disp;
    logic [COST_W-1:0] out_cost;
    logic              out_unique;
    logic              err_seq;

    int total = 0;
    int bad   = 0;
    int n_valid = 0;
    int n_err   = 0;
    int pix[NUM_DISP];

    wta_disparity_select #(
        .NUM_DISP(NUM_DISP), .DISP_W(DISP_W), .COST_W(COST_W), .UNIQ(UNIQ)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cost_valid(cost_valid), .cost_first(cost_first),
        .cost(cost), .out_valid(out_valid), .out_disp(out_disp), .out_cost(out_cost),
        .out_unique(out_unique), .err_seq(err_seq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: collect a whole pixel, then pick min / second-min by plain search.
    int  q[$];
    bit  open = 0;
    bit  e_valid = 0, e_err = 0, e_uniq = 0;
    int  e_disp = 0, e_cost = 0;

    task automatic model_result();
        int b, bd, s;
        b = 1 << 30; bd = 0; s = 1 << 30;
        for (int i = 0; i < NUM_DISP; i++)
            if (q[i] < b) begin b = q[i]; bd = i; end
        for (int i = 0; i < NUM_DISP; i++)
            if (i != bd && q[i] < s) s = q[i];
        e_disp = bd;
        e_cost = b;
        e_uniq = (s * 16) > (b * (16 + UNIQ));
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            open = 0; q.delete();
            e_valid = 0; e_err = 0; e_disp = 0; e_cost = 0; e_uniq = 0;
        end else begin
            e_valid = 0; e_err = 0;
            if (cost_valid) begin
                if (cost_first) begin
                    if (open) e_err = 1;
                    q.delete();
                    q.push_back(int'(cost));
                    open = 1;
                end else if (!open) begin
                    e_err = 1;
                end else begin
                    q.push_back(int'(cost));
                    if (q.size() == NUM_DISP) begin
                        model_result();
                        open = 0;
                        e_valid = 1;
                    end
                end
            end
        end
        #1;
        check("out_valid", out_valid, e_valid);
        check("err_seq", err_seq, e_err);
        check("out_disp", out_disp, e_disp);
        check("out_cost", out_cost, e_cost);
        check("out_unique", out_unique, e_uniq);
        if (out_valid) n_valid++;
        if (err_seq) n_err++;
    end

    task automatic beat(input logic v, input logic f, input logic [COST_W-1:0] c);
        @(negedge clk);
        cost_valid = v; cost_first = f; cost = c;
    endtask

    task automatic idle(input int n);
        repeat (n) beat(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic send_pix(input int n, input int gap_pct);
        for (int d = 0; d < n; d++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) beat(1'b0, 1'b0, 8'($urandom));
            beat(1'b1, d == 0, 8'(pix[d]));
        end
    endtask

    initial begin
        int e0, v0;
        idle(3);
        check("rst_valid", out_valid, 0);
        check("rst_disp", out_disp, 0);
        check("rst_cost", out_cost, 0);
        check("rst_uniq", out_unique, 0);
        check("rst_err", err_seq, 0);
        rst_n = 1'b1;
        idle(2);

        // clear winner with a distinct runner-up
        for (int i = 0; i < NUM_DISP; i++) pix[i] = 100;
        pix[37] = 20; pix[5] = 40;
        send_pix(NUM_DISP, 0);
        idle(1);
        check("t1_valid", out_valid, 1);
        check("t1_disp", out_disp, 37);
        check("t1_cost", out_cost, 20);
        check("t1_uniq", out_unique, 1);
        idle(1);
        check("t1_pulse", out_valid, 0);
        check("t1_hold", out_disp, 37);

        // tie keeps lowest disparity
        for (int i = 0; i < NUM_DISP; i++) pix[i] = 200;
        pix[3] = 10; pix[9] = 10;
        send_pix(NUM_DISP, 25);
        idle(1);
        check("tie_disp", out_disp, 3);
        check("tie_cost", out_cost, 10);
        check("tie_uniq", out_unique, 0);

        // cost_first at d = 30 aborts the open pixel
        e0 = n_err; v0 = n_valid;
        for (int i = 0; i < NUM_DISP; i++) pix[i] = int'($urandom_range(0, 255));
        send_pix(30, 0);
        for (int i = 0; i < NUM_DISP; i++) pix[i] = 50 + i;
        send_pix(NUM_DISP, 0);
        idle(2);
        check("abort_err", n_err - e0, 1);
        check("abort_nres", n_valid - v0, 1);
        check("abort_disp", out_disp, 0);
        check("abort_cost", out_cost, 50);

        // stray beat in IDLE is dropped
        e0 = n_err;
        beat(1'b1, 1'b0, 8'd3);
        idle(1);
        check("idle_err", err_seq, 1);
        idle(1);
        check("idle_err_cnt", n_err - e0, 1);
        check("idle_disp_hold", out_disp, 0);

        // asynchronous reset mid-pixel
        for (int i = 0; i < NUM_DISP; i++) pix[i] = int'($urandom_range(1, 255));
        pix[63] = 0;
        v0 = n_valid;
        send_pix(41, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_disp", out_disp, 0);
        check("arst_cost", out_cost, 0);
        check("arst_uniq", out_unique, 0);
        check("arst_err", err_seq, 0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        check("arst_nores", n_valid - v0, 0);
        send_pix(NUM_DISP, 10);
        idle(1);
        check("arst_disp63", out_disp, 63);
        check("arst_cost0", out_cost, 0);
        check("arst_uniq1", out_unique, 1);

        // saturated costs everywhere
        for (int i = 0; i < NUM_DISP; i++) pix[i] = 255;
        send_pix(NUM_DISP, 0);
        idle(1);
        check("max_disp", out_disp, 0);
        check("max_cost", out_cost, 255);
        check("max_uniq", out_unique, 0);

        // random pixels, half back-to-back, half with gaps; narrow ranges provoke ties
        for (int p = 0; p < 100; p++) begin
            for (int i = 0; i < NUM_DISP; i++)
                pix[i] = (p % 3 == 0) ? int'($urandom_range(0, 15))
                                      : int'($urandom_range(0, 255));
            send_pix(NUM_DISP, (p % 2 == 0) ? 0 : 20);
        end
        idle(3);
        check("n_results", n_valid, 105);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
